// File: rtl/pw_checker.sv
// Collects four BCD digits while pwstart is high, compares them with PASSWORD and reports via a pwdone strobe.
// Tracks per-digit idle timeout and locks out further attempts after MAX_FAIL consecutive failures.
module pw_checker #(
    parameter logic [15:0] PASSWORD       = 16'h1234,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCK_CYCLES    = 1_000_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwstart,
    input  logic [3:0]  digit_in,
    input  logic        digit_valid,
    input  logic        clear,
    output logic        pwdone,
    output logic        pw_correct,
    output logic [2:0]  digit_cnt,
    output logic [15:0] entered,
    output logic        locked
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic            pwdone_q, pwdone_d;
    logic            pw_correct_q, pw_correct_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [15:0]     entered_q, entered_d;
    logic            locked_q, locked_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic [LW-1:0]   lock_q, lock_d;
    logic            fail_inc;

    always_comb begin
        state_d      = state_q;
        pwdone_d     = (state_q == S_DONE);
        pw_correct_d = pw_correct_q;
        cnt_d        = cnt_q;
        entered_d    = entered_q;
        tmo_d        = tmo_q;
        fail_d       = fail_q;
        lock_d       = (lock_q != '0) ? lock_q - 1'b1 : '0;
        fail_inc     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pwstart) begin
                    if (locked_q) begin
                        state_d      = S_DONE;
                        pw_correct_d = 1'b0;
                    end else begin
                        state_d   = S_COLLECT;
                        cnt_d     = '0;
                        entered_d = '0;
                        tmo_d     = '0;
                    end
                end
            end
            S_COLLECT: begin
                if (!pwstart) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    entered_d = '0;
                    tmo_d     = '0;
                end else if (clear) begin
                    cnt_d     = '0;
                    entered_d = '0;
                    tmo_d     = '0;
                end else if (digit_valid && (digit_in <= 4'd9)) begin
                    // Digits fill from the most significant nibble downwards.
                    entered_d = entered_q | ({digit_in, 12'h000} >> (4 * cnt_q));
                    cnt_d     = cnt_q + 3'd1;
                    tmo_d     = '0;
                    if (cnt_q == 3'd3) begin
                        state_d = S_CHECK;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = S_DONE;
                    pw_correct_d = 1'b0;
                    fail_inc     = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CHECK: begin
                state_d      = S_DONE;
                pw_correct_d = (entered_q == PASSWORD);
                if (entered_q == PASSWORD) begin
                    fail_d = '0;
                end else begin
                    fail_inc = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!pwstart) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    entered_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fail_inc && (fail_q != FW'(MAX_FAIL))) begin
            fail_d = fail_q + 1'b1;
        end

        // Reaching the failure limit arms the lockout one cycle later, in step with pwdone.
        if (fail_q == FW'(MAX_FAIL)) begin
            fail_d = '0;
            lock_d = LW'(LOCK_CYCLES);
        end

        locked_d = (lock_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pwdone_q     <= 1'b0;
            pw_correct_q <= 1'b0;
            cnt_q        <= '0;
            entered_q    <= '0;
            locked_q     <= 1'b0;
            tmo_q        <= '0;
            fail_q       <= '0;
            lock_q       <= '0;
        end else begin
            state_q      <= state_d;
            pwdone_q     <= pwdone_d;
            pw_correct_q <= pw_correct_d;
            cnt_q        <= cnt_d;
            entered_q    <= entered_d;
            locked_q     <= locked_d;
            tmo_q        <= tmo_d;
            fail_q       <= fail_d;
            lock_q       <= lock_d;
        end
    end

    assign pwdone     = pwdone_q;
    assign pw_correct = pw_correct_q;
    assign digit_cnt  = cnt_q;
    assign entered    = entered_q;
    assign locked     = locked_q;

endmodule

// File: doc/pw_checker.md
Name: pw_checker

Overview:
- Password-entry and check stage directly upstream of the parking controller.
- While the controller holds pwstart high, this block collects four BCD digits from the switch keypad and compares them against a stored code.
- It reports the result to the controller as a one-cycle pwdone pulse, with pw_correct valid on that same cycle.
- It also enforces an entry timeout and a lockout after repeated failures, and exposes entry progress for the 7-segment display.

Parameters:
- PASSWORD, 16'h1234: four-digit BCD code; digit 1 is in [15:12], digit 4 is in [3:0].
- TIMEOUT_CYCLES, 500_000_000: maximum idle cycles between digits while collecting. 5 s at 100 MHz.
- MAX_FAIL, 3: number of consecutive failed results that triggers lockout.
- LOCK_CYCLES, 1_000_000_000: lockout duration in cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- pwstart  in  1  level from the controller; high while the controller waits for a password.
- digit_in  in  4  BCD digit from the switches.
- digit_valid  in  1  one-cycle, already-debounced pulse; captures digit_in.
- clear  in  1  one-cycle pulse; discards the digits entered so far.
- pwdone  out  1  one-cycle result strobe.
- pw_correct  out  1  result; valid when pwdone=1, held until the next result.
- digit_cnt  out  3  digits entered so far, 0..4.
- entered  out  16  digits entered so far, left-aligned, with unentered nibbles = 0.
- locked  out  1  high while lockout is active.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; pwdone=0, pw_correct=0, digit_cnt=0, entered=0, locked=0; fail_cnt=0, timeout counter=0, lock counter=0. Reset takes priority over every other input, including mid-entry.
- All outputs are registered. The state register is updated on posedge clk only.
- IDLE:
  - pwstart=1 and locked=0 -> COLLECT; buffer and timeout counter cleared.
  - pwstart=1 and locked=1 -> DONE with pw_correct=0. fail_cnt does not change.
  - digit_valid and clear are ignored in IDLE.
- COLLECT:
  - A digit_valid with digit_in<=9 shifts the digit into entered at position digit_cnt, increments digit_cnt, and clears the timeout counter.
  - digit_valid with digit_in>9 is ignored: no capture and no timeout clear.
  - clear=1 sets entered=0 and digit_cnt=0 and clears the timeout counter. If clear and digit_valid occur in the same cycle, clear wins.
  - The edge that captures the 4th digit moves the block to CHECK.
  - When the timeout counter reaches TIMEOUT_CYCLES-1 -> DONE with pw_correct=0 (counts as a failure).
  - pwstart=0 (abort) -> IDLE; buffer cleared, no pwdone, fail_cnt unchanged.
- CHECK (1 cycle):
  - pw_correct <= (entered==PASSWORD). State -> DONE.
  - Success clears fail_cnt. Failure increments fail_cnt, saturating at MAX_FAIL.
- DONE (1 cycle): pwdone=1. State -> RELEASE.
- RELEASE:
  - Waits for pwstart=0, then -> IDLE; buffer and digit_cnt cleared on entry to IDLE.
  - The controller drops pwstart on the cycle after pwdone, so RELEASE normally lasts 1 cycle.
- Latency: pwdone is high in the second cycle after the edge that samples the 4th digit_valid. Edge N samples the digit, edge N+1 performs the compare, pwdone=1 from edge N+2 to edge N+3.
- Lockout:
  - When fail_cnt reaches MAX_FAIL, the lock counter loads LOCK_CYCLES, locked=1, and fail_cnt is cleared.
  - The lock counter decrements every cycle regardless of state; locked=0 when it reaches 0.
  - While locked, every pwstart request is rejected through IDLE->DONE.
- Counter widths: $clog2(param+1) bits. No wrap-around; counters saturate or reload as described above.
- pwdone is never high for two consecutive cycles. At most one pwdone is issued per pwstart assertion.

Test Plan (TIMEOUT_CYCLES=20, LOCK_CYCLES=50, MAX_FAIL=3):
- Correct entry: pwstart=1, digits 1,2,3,4 on separate cycles -> digit_cnt steps 1..4, entered=16'h1234; pwdone=1 for one cycle, 2 cycles after the 4th digit, with pw_correct=1. Drop pwstart -> IDLE, digit_cnt=0.
- Wrong code plus edge cases:
  - Digits 1,2,3,5 -> pwdone with pw_correct=0, fail_cnt=1.
  - Digit 12 mid-entry -> ignored, digit_cnt unchanged.
  - clear plus digit_valid in the same cycle -> digit_cnt=0.
- Timeout: pwstart=1, enter digit 7, then idle for 20 cycles -> pwdone with pw_correct=0, counted as a failure.
- Lockout:
  - Three failed entries -> locked=1 after the third pwdone.
  - A new pwstart while locked -> pwdone with pw_correct=0 within 2 cycles.
  - After 50 cycles, locked=0; entering 1,2,3,4 then succeeds.
- Abort and reset:
  - pwstart drops after 2 digits -> no pwdone, IDLE, entered=0.
  - rst=1 in COLLECT with 3 digits entered -> all outputs 0 at the next edge, lockout cleared.
